// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I decode definitions for the operand-fetch stage:
//   opcode_e    - major opcodes recognised by the decoder
//   imm_type_e  - immediate format selector driven into imm_gen
//   *_LSB/_W    - instruction field slice positions and widths
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned OPC_LSB     = 0;
    localparam int unsigned OPC_W       = 7;
    localparam int unsigned RD_LSB      = 7;
    localparam int unsigned F3_LSB      = 12;
    localparam int unsigned F3_W        = 3;
    localparam int unsigned RS1_LSB     = 15;
    localparam int unsigned RS2_LSB     = 20;
    localparam int unsigned F7_LSB      = 25;
    localparam int unsigned F7_W        = 7;
    localparam int unsigned REG_FIELD_W = 5;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate generator.
//   i_instr  in  [31:7]      instruction word above the opcode field
//   i_type   in  imm_type_e  immediate format
//   o_imm    out DATA_WIDTH  sign-extended immediate (0 for IMM_NONE)
// ---------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:7]           i_instr,
    input  imm_type_e             i_type,
    output logic [DATA_WIDTH-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_type)
            IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends when DATA_WIDTH exceeds 32.
    assign o_imm = DATA_WIDTH'($signed(w_imm32));

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Decode / operand-fetch stage. Decodes an RV32I word, drives register-file
// read addresses, tracks in-flight destinations in a busy scoreboard,
// stalls on RAW/WAW hazards, bypasses same-cycle writeback data and
// registers one decoded op for execute behind a valid/ready handshake.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc upstream handshake and instruction
//   rs1_addr/rs2_addr                register-file read addresses (comb)
//   rs1_data/rs2_data                register-file read data (pre-write)
//   wb_en/wb_addr/wb_data            writeback commit
//   flush                            kill the op held in the output register
//   out_valid/out_ready              downstream handshake
//   out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rd_we,
//   out_opcode, out_funct3, out_funct7   registered decoded op
// ---------------------------------------------------------------------------
module operand_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_rs1_val,
    output logic [DATA_WIDTH-1:0] out_rs2_val,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_we,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Field slices
    logic [OPC_W-1:0]      w_opcode;
    logic [ADDR_WIDTH-1:0] w_rs1;
    logic [ADDR_WIDTH-1:0] w_rs2;
    logic [ADDR_WIDTH-1:0] w_rd;

    assign w_opcode = in_instr[OPC_LSB +: OPC_W];
    assign w_rs1    = ADDR_WIDTH'(in_instr[RS1_LSB +: REG_FIELD_W]);
    assign w_rs2    = ADDR_WIDTH'(in_instr[RS2_LSB +: REG_FIELD_W]);
    assign w_rd     = ADDR_WIDTH'(in_instr[RD_LSB  +: REG_FIELD_W]);
    assign rs1_addr = w_rs1;
    assign rs2_addr = w_rs2;

    // Decode
    logic      w_rs1_used;
    logic      w_rs2_used;
    logic      w_dec_we;
    logic      w_rd_we;
    imm_type_e w_imm_type;

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_dec_we   = 1'b0;
        w_imm_type = IMM_NONE;
        case (w_opcode)
            OPC_OP: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_dec_we   = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                w_rs1_used = 1'b1;
                w_dec_we   = 1'b1;
                w_imm_type = IMM_I;
            end
            OPC_STORE: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm_type = IMM_B;
            end
            OPC_JAL: begin
                w_dec_we   = 1'b1;
                w_imm_type = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_dec_we   = 1'b1;
                w_imm_type = IMM_U;
            end
            // Unknown opcodes travel as no-ops so execute can trap on them.
            default: ;
        endcase
    end

    assign w_rd_we = w_dec_we && (w_rd != '0);

    logic [DATA_WIDTH-1:0] w_imm;

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .i_instr (in_instr[31:7]),
        .i_type  (w_imm_type),
        .o_imm   (w_imm)
    );

    // Scoreboard, hazard and bypass
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_hazard;
    logic             w_accept;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_pc;
    logic [DATA_WIDTH-1:0] r_out_rs1_val;
    logic [DATA_WIDTH-1:0] r_out_rs2_val;
    logic [DATA_WIDTH-1:0] r_out_imm;
    logic [ADDR_WIDTH-1:0] r_out_rd;
    logic                  r_out_rd_we;
    logic [6:0]            r_out_opcode;
    logic [2:0]            r_out_funct3;
    logic [6:0]            r_out_funct7;

    assign w_byp1 = wb_en && (wb_addr == w_rs1) && (w_rs1 != '0);
    assign w_byp2 = wb_en && (wb_addr == w_rs2) && (w_rs2 != '0);

    // A writeback landing this cycle resolves the RAW dependency via bypass.
    assign w_raw1   = w_rs1_used && (w_rs1 != '0) && r_busy[w_rs1] && !w_byp1;
    assign w_raw2   = w_rs2_used && (w_rs2 != '0) && r_busy[w_rs2] && !w_byp2;
    assign w_waw    = w_rd_we && r_busy[w_rd];
    assign w_hazard = w_raw1 || w_raw2 || w_waw;

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    logic [DATA_WIDTH-1:0] w_rs1_val;
    logic [DATA_WIDTH-1:0] w_rs2_val;

    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1_used && (w_rs1 != '0)) begin
            w_rs1_val = w_byp1 ? wb_data : rs1_data;
        end
        if (w_rs2_used && (w_rs2 != '0)) begin
            w_rs2_val = w_byp2 ? wb_data : rs2_data;
        end
    end

    // Set is applied last so an accept and a writeback to the same index
    // leave the entry busy. Flush and accept never coincide.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (flush && r_out_valid && r_out_rd_we) begin
            w_busy_nxt[r_out_rd] = 1'b0;
        end
        if (w_accept && w_rd_we) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Output pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_rs1_val <= '0;
            r_out_rs2_val <= '0;
            r_out_imm     <= '0;
            r_out_rd      <= '0;
            r_out_rd_we   <= 1'b0;
            r_out_opcode  <= '0;
            r_out_funct3  <= '0;
            r_out_funct7  <= '0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= in_pc;
            r_out_rs1_val <= w_rs1_val;
            r_out_rs2_val <= w_rs2_val;
            r_out_imm     <= w_imm;
            r_out_rd      <= w_rd;
            r_out_rd_we   <= w_rd_we;
            r_out_opcode  <= w_opcode;
            r_out_funct3  <= in_instr[F3_LSB +: F3_W];
            r_out_funct7  <= in_instr[F7_LSB +: F7_W];
        end else if (flush || out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_rs1_val = r_out_rs1_val;
    assign out_rs2_val = r_out_rs2_val;
    assign out_imm     = r_out_imm;
    assign out_rd      = r_out_rd;
    assign out_rd_we   = r_out_rd_we;
    assign out_opcode  = r_out_opcode;
    assign out_funct3  = r_out_funct3;
    assign out_funct7  = r_out_funct7;

endmodule
